// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
//   Bundle between the decode stage and the hazard scoreboard.
//   master : decode side, drives the ID instruction fields, flush and mem_wait,
//            receives stall, forward selects and status.
//   slave  : scoreboard side.
//   Parameters must match the ones given to hazard_scoreboard so that the
//   forward-select width lines up.
//   Fields:
//     id_valid, id_src1, id_src2, id_uses_src2, id_dest, id_wb_en, id_is_load
//     flush, mem_wait                 -> scoreboard
//     stall, fwd_sel1, fwd_sel2, ex_valid, busy <- scoreboard
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3
);
  localparam int FWD_W = $clog2(DEPTH);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_uses_src2;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_wb_en;
  logic                  id_is_load;
  logic                  flush;
  logic                  mem_wait;
  logic                  stall;
  logic [FWD_W-1:0]      fwd_sel1;
  logic [FWD_W-1:0]      fwd_sel2;
  logic                  ex_valid;
  logic                  busy;

  modport master (
    output id_valid, id_src1, id_src2, id_uses_src2, id_dest, id_wb_en,
           id_is_load, flush, mem_wait,
    input  stall, fwd_sel1, fwd_sel2, ex_valid, busy
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_uses_src2, id_dest, id_wb_en,
           id_is_load, flush, mem_wait,
    output stall, fwd_sel1, fwd_sel2, ex_valid, busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Combined load-use hazard detector and forwarding unit. Every writer from
//   EXE (entry 0) to the last writeback stage (entry DEPTH-1) is tracked in a
//   shift register; the ID operands are compared against it, a load-use stall
//   is raised combinationally and forward selects are registered so they line
//   up with the instruction once it is in EXE.
//   Ports:
//     clk, rst  clock, asynchronous active-high reset
//     bus       hazard_scoreboard_if.slave (ID fields, flush, mem_wait in;
//               stall, fwd_sel1/2, ex_valid, busy out)
//   Optional build macro SCOREBOARD_PERF_EN adds:
//     perf_clr   synchronous clear of both counters (wins over increment)
//     stall_cnt  saturating count of load-use stall cycles
//     freeze_cnt saturating count of mem_wait cycles
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_LAT   = 2
) (
  input  logic clk,
  input  logic rst,
  hazard_scoreboard_if.slave bus
`ifdef SCOREBOARD_PERF_EN
  ,
  input  logic        perf_clr,
  output logic [15:0] stall_cnt,
  output logic [15:0] freeze_cnt
`endif
);
  localparam int FWD_W = $clog2(DEPTH);
  localparam int unsigned D_U   = DEPTH;
  localparam int unsigned LAT_U = LOAD_LAT;

  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      wb_q;
  logic [DEPTH-1:0]      load_q;
  logic [REG_ADDR_W-1:0] dest_q [DEPTH];
  logic [FWD_W-1:0]      fwd1_q, fwd2_q;

  logic             hit1, hit2, haz1, haz2;
  logic [FWD_W-1:0] sel1, sel2;
  logic             hazard, issue;

  // Scan from the youngest entry; the first hit wins and older ones are
  // ignored. A hit in the last entry forwards nothing because its register
  // file write lands on the same edge the consumer advances.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    haz1 = 1'b0;
    haz2 = 1'b0;
    sel1 = '0;
    sel2 = '0;
    for (int unsigned i = 0; i < D_U; i++) begin
      if (!hit1 && valid_q[i] && wb_q[i] && bus.id_src1 != '0 &&
          dest_q[i] == bus.id_src1) begin
        hit1 = 1'b1;
        haz1 = load_q[i] && (i + 1 < LAT_U);
        sel1 = (i == D_U - 1) ? '0 : FWD_W'(i + 1);
      end
      if (!hit2 && bus.id_uses_src2 && valid_q[i] && wb_q[i] &&
          bus.id_src2 != '0 && dest_q[i] == bus.id_src2) begin
        hit2 = 1'b1;
        haz2 = load_q[i] && (i + 1 < LAT_U);
        sel2 = (i == D_U - 1) ? '0 : FWD_W'(i + 1);
      end
    end
  end

  assign hazard = bus.id_valid && !bus.flush && (haz1 || haz2);
  assign issue  = bus.id_valid && !bus.flush && !hazard;

  assign bus.stall    = bus.mem_wait || hazard;
  assign bus.fwd_sel1 = fwd1_q;
  assign bus.fwd_sel2 = fwd2_q;
  assign bus.ex_valid = valid_q[0];
  assign bus.busy     = |valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      wb_q    <= '0;
      load_q  <= '0;
      fwd1_q  <= '0;
      fwd2_q  <= '0;
      for (int unsigned i = 0; i < D_U; i++) dest_q[i] <= '0;
    end else if (!bus.mem_wait) begin
      // A bubble is just valid=0; its other fields are don't-care.
      valid_q <= {valid_q[DEPTH-2:0], issue};
      wb_q    <= {wb_q[DEPTH-2:0], bus.id_wb_en};
      load_q  <= {load_q[DEPTH-2:0], bus.id_is_load};
      for (int unsigned i = 1; i < D_U; i++) dest_q[i] <= dest_q[i-1];
      dest_q[0] <= bus.id_dest;
      fwd1_q    <= issue ? sel1 : '0;
      fwd2_q    <= issue ? sel2 : '0;
    end
  end

`ifdef SCOREBOARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      freeze_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (hazard && stall_cnt != '1)        stall_cnt  <= stall_cnt + 16'd1;
      if (bus.mem_wait && freeze_cnt != '1) freeze_cnt <= freeze_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed 5-stage hazard detector and forwarding unit; one block replaces both.
- Tracks every in-flight writer from EXE to the last writeback stage in a shift register of DEPTH entries.
- Compares the operands of the instruction in ID against those entries, raises a load-use stall, and registers forward selects that take effect when the instruction enters EXE.
- Supports configurable pipeline depth, load latency, immediate-only operands, flush and a memory-wait freeze.

Parameters:
- REG_ADDR_W, 5, register address width.
- DEPTH, 3, tracked stages after ID (0 = EXE … DEPTH-1 = WB); legal range 2..8.
- LOAD_LAT, 2, first stage index at which load data can be forwarded; legal range 1..DEPTH-1.
- FWD_W, $clog2(DEPTH), width of the forward-select fields (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  REG_ADDR_W  rs of the ID instruction.
- id_src2  in  REG_ADDR_W  rt of the ID instruction.
- id_uses_src2  in  1  0 for immediate forms; src2 then ignored.
- id_dest  in  REG_ADDR_W  destination register.
- id_wb_en  in  1  instruction writes the register file.
- id_is_load  in  1  instruction is a load.
- flush  in  1  kill the ID instruction (branch/jump taken).
- mem_wait  in  1  memory not ready; freeze the whole tracked pipeline.
- stall  out  1  hold PC and IF/ID; insert a bubble into EXE.
- fwd_sel1  out  FWD_W  EXE operand-1 source: 0 = register file, k = result of stage k.
- fwd_sel2  out  FWD_W  EXE operand-2 source; same encoding as fwd_sel1.
- ex_valid  out  1  stage-0 entry is valid.
- busy  out  1  any tracked entry is valid.

Behaviour:
- Reset is asynchronous and active-high on rst; single clock clk, rising edge. On reset all entries are invalid and stall, fwd_sel1, fwd_sel2, ex_valid and busy are 0.
- Entry fields: valid, dest, wb_en, is_load.
- Match rule: for source s, entry i matches when valid=1, wb_en=1, dest==s and s!=0. Register 0 never matches.
- src2 is compared only when id_uses_src2=1.
- Priority: the youngest matching entry (lowest i) wins; older matches are ignored.
- Load-use hazard: the winning match is a load and i+1 < LOAD_LAT, with id_valid=1 and flush=0.
- stall (combinational) = mem_wait OR load-use hazard.
- Forward select for the winner, computed in ID and registered at the edge on which the instruction advances:
  - sel = i+1 if i+1 <= DEPTH-1.
  - sel = 0 if i == DEPTH-1, because that writer's register-file write completes on that edge.
  - No match gives sel = 0.
- Advance, when mem_wait=0:
  - Entries shift i to i+1 and entry DEPTH-1 retires.
  - Entry 0 loads the ID instruction if id_valid=1, flush=0 and there is no load-use hazard; otherwise entry 0 loads a bubble with valid=0 and fwd_sel = 0.
- Freeze, when mem_wait=1: all entries and fwd_sel registers hold; stall=1.
- Simultaneous events:
  - flush together with a hazard: the bubble is inserted, stall=0 unless mem_wait=1.
  - mem_wait=1 has priority over flush; the flush must be held by the source until mem_wait falls.
- Consecutive stalls: the condition is re-evaluated every cycle. With LOAD_LAT=2 a load-use stall lasts exactly 1 cycle; in general it lasts LOAD_LAT-1-i cycles.
- Latency: stall is combinational (0 cycles); fwd_sel is valid 1 cycle after the issuing edge, aligned with the instruction in EXE.
- Reset mid-operation clears all entries immediately; there is no pending forwarding after reset is released.

Optional Feature:
- Macro: SCOREBOARD_PERF_EN.
- When defined:
  - Adds outputs stall_cnt (16 bits), counting cycles with a load-use stall.
  - Adds freeze_cnt (16 bits), counting cycles with mem_wait=1.
  - Both counters saturate at 16'hFFFF and are cleared by rst.
  - Adds input perf_clr, a synchronous clear of both counters that overrides increment in the same cycle.
- When not defined: these ports and counters do not exist, and the remaining logic is identical.

Test Plan:
- ALU dependency: add r3 <- r1,r2, then add r5 <- r3,r4 next cycle → no stall; fwd_sel1=1 one cycle later; fwd_sel2=0.
- Load-use: lw r4, then add r6 <- r4,r4 → stall=1 for 1 cycle and a bubble in EXE (ex_valid=0); then fwd_sel1=fwd_sel2=2. Repeat with LOAD_LAT=3, DEPTH=4 → 2 stall cycles.
- Distance and priority: a writer of r7 three instructions ahead gives sel=0. Two writers of r7 at entries 0 and 1 give sel=1 (youngest wins). A dest of r0 is never forwarded. An immediate op with id_uses_src2=0 that matches on src2 gives fwd_sel2=0.
- mem_wait during the load stall: assert for 3 cycles → entries and fwd_sel hold and stall=1 throughout; after release the sequence resumes identically to the uninterrupted case.
- flush with a load-use hazard present → stall=0; entry 0 becomes a bubble; the load retires normally.
- rst asserted asynchronously mid-cycle with 3 valid entries → busy, stall and fwd_sel go to 0 immediately. With SCOREBOARD_PERF_EN: 5 stalls give stall_cnt=5; perf_clr gives 0; a forced saturation stays at FFFF.
